// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common
//   Shared pipeline types and constants.
//   - control_type   : control word carried from decode through write-back
//   - mem_state_type : memory-stage access sequencer states
//   - F3_*           : funct3 load/store size encodings
//   - access_bytes   : width in bytes of a funct3 size (unused codes -> word)
//   - is_signed_load : funct3 size requests sign extension
// ---------------------------------------------------------------------------
package common;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BYTE_U = 3'b100;
    localparam logic [2:0] F3_HALF_U = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic [4:0] rd;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
    } control_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_type;

    // Unused encodings (011, 110, 111) fall back to a full word.
    function automatic logic [2:0] access_bytes(input logic [2:0] size);
        case (size)
            F3_BYTE, F3_BYTE_U: return 3'd1;
            F3_HALF, F3_HALF_U: return 3'd2;
            default:            return 3'd4;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [2:0] size);
        return (size == F3_BYTE) || (size == F3_HALF);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ---------------------------------------------------------------------------
// load_store_align
//   Purely combinational data-alignment helper for a 32-bit little-endian
//   memory port. Usable by any load/store path (data or fetch).
//   Ports:
//     i_offset      byte offset within the word (address[1:0])
//     i_size        funct3 access size
//     i_store_data  store operand (rs2)
//     i_rdata       raw memory read word
//     o_be          byte enables for the access
//     o_wdata       store data replicated across all lanes of its width
//     o_load_data   read word shifted down by the offset and extended
//     o_misaligned  access crosses its natural alignment
// ---------------------------------------------------------------------------
module load_store_align
    import common::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [2:0]  w_bytes;
    logic        w_signed;
    logic [31:0] w_shifted;

    assign w_bytes   = access_bytes(i_size);
    assign w_signed  = is_signed_load(i_size);
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_store_data;
        o_load_data  = w_shifted;
        o_misaligned = 1'b0;
        case (w_bytes)
            3'd1: begin
                o_be        = 4'b0001 << i_offset;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
            end
            3'd2: begin
                o_be         = 4'b0011 << i_offset;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
                o_misaligned = i_offset[0];
            end
            default: begin
                o_misaligned = (i_offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Memory-access stage of the five-stage RISC-V pipeline. Accepts the
//   execute-stage bundle, runs loads/stores on a req/gnt/rvalid data port and
//   presents a registered MEM/WB bundle.
//   Ports:
//     clk, reset          pipeline clock, asynchronous active-high reset
//     in_valid            execute bundle valid (accepted only when not stalled)
//     control_in          control word from execute
//     alu_data            ALU result / effective address
//     memory_data         store operand
//     stall               access outstanding; upstream holds its bundle
//     out_valid           one-cycle pulse per retired bundle
//     control_out         registered control word of the retired bundle
//     alu_data_out        registered alu_data of the retired bundle
//     load_data           extended load result, 0 for non-loads
//     misaligned          retired access was misaligned (no bus access)
//     mem_req/we/addr/be/wdata   data-memory request side
//     mem_gnt             request accepted this cycle
//     mem_rvalid/rdata    load response
// ---------------------------------------------------------------------------
module memory_stage
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  control_type control_in,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    output logic        stall,
    output logic        out_valid,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    mem_state_type r_state;
    mem_state_type w_state_next;

    // Latched access (held stable for the whole request/response).
    control_type r_ctrl;
    logic [31:0] r_alu;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    // MEM/WB output register.
    logic        r_out_valid;
    control_type r_ctrl_out;
    logic [31:0] r_alu_out;
    logic [31:0] r_load_data;
    logic        r_misaligned;

    logic        w_idle;
    logic        w_accept;
    logic        w_is_mem;
    logic        w_start;
    logic        w_retire_now;
    logic        w_store_done;
    logic        w_load_done;
    logic [1:0]  w_align_offset;
    logic [2:0]  w_align_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_misaligned;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & in_valid;
    assign w_is_mem = control_in.mem_read | control_in.mem_write;

    // One aligner serves both ends: in IDLE it decodes the incoming bundle,
    // while busy it extracts the response using the latched offset and size.
    assign w_align_offset = w_idle ? alu_data[1:0]       : r_alu[1:0];
    assign w_align_size   = w_idle ? control_in.mem_size : r_ctrl.mem_size;

    load_store_align u_align (
        .i_offset     (w_align_offset),
        .i_size       (w_align_size),
        .i_store_data (memory_data),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_misaligned)
    );

    // Non-memory ops and misaligned accesses bypass the bus entirely.
    assign w_start      = w_accept & w_is_mem & ~w_misaligned;
    assign w_retire_now = w_accept & ~w_start;
    assign w_store_done = (r_state == REQ) & mem_gnt & r_mem_we;
    assign w_load_done  = (r_state == RESP) & mem_rvalid;

    // -----------------------------------------------------------------------
    // Access sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_state_next = r_mem_we ? IDLE : RESP;
                end
            end
            RESP: begin
                // rvalid is only honoured here; earlier responses are ignored.
                if (mem_rvalid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Access latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl      <= '0;
            r_alu       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else if (w_start) begin
            r_ctrl      <= control_in;
            r_alu       <= alu_data;
            r_mem_we    <= control_in.mem_write;
            r_mem_addr  <= {alu_data[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_ctrl_out   <= '0;
            r_alu_out    <= '0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_out_valid <= w_retire_now | w_store_done | w_load_done;
            if (w_retire_now) begin
                r_ctrl_out   <= control_in;
                r_alu_out    <= alu_data;
                r_load_data  <= '0;
                r_misaligned <= w_is_mem & w_misaligned;
            end else if (w_store_done | w_load_done) begin
                r_ctrl_out   <= r_ctrl;
                r_alu_out    <= r_alu;
                r_load_data  <= w_load_done ? w_load_data : 32'd0;
                r_misaligned <= 1'b0;
            end
        end
    end

    assign stall        = ~w_idle;
    assign mem_req      = (r_state == REQ);
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_be       = r_mem_be;
    assign mem_wdata    = r_mem_wdata;
    assign out_valid    = r_out_valid;
    assign control_out  = r_ctrl_out;
    assign alu_data_out = r_alu_out;
    assign load_data    = r_load_data;
    assign misaligned   = r_misaligned;

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage: directed scenarios plus randomized
//   bundles with random grant/response delays, scored against a byte-level
//   reference model.
// ---------------------------------------------------------------------------
module tb_memory_stage;
    import common::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    control_type control_in = '0;
    logic [31:0] alu_data = '0;
    logic [31:0] memory_data = '0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        stall;
    logic        out_valid;
    control_type control_out;
    logic [31:0] alu_data_out;
    logic [31:0] load_data;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .control_in   (control_in),
        .alu_data     (alu_data),
        .memory_data  (memory_data),
        .stall        (stall),
        .out_valid    (out_valid),
        .control_out  (control_out),
        .alu_data_out (alu_data_out),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] load_data;
        logic        mis;
        logic        access;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] lat;
    } exp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic control_type mk_ctrl(input logic rd_m, input logic wr_m,
                                            input logic [2:0] size, input logic [4:0] rd);
        control_type c;
        c.reg_write = ~wr_m;
        c.rd        = rd;
        c.mem_read  = rd_m;
        c.mem_write = wr_m;
        c.mem_size  = size;
        return c;
    endfunction

    // Reference: byte-count arithmetic on the address and data words.
    function automatic exp_t model_op(input control_type c, input logic [31:0] a,
                                      input logic [31:0] sd, input logic [31:0] word,
                                      input int gd, input int rdly);
        exp_t        e;
        int          nb;
        int          off;
        logic [31:0] v;
        logic [31:0] mask;
        bit          is_mem;
        e      = '0;
        off    = int'(a[1:0]);
        if (c.mem_size == 3'd0 || c.mem_size == 3'd4) nb = 1;
        else if (c.mem_size == 3'd1 || c.mem_size == 3'd5) nb = 2;
        else nb = 4;
        is_mem   = c.mem_read || c.mem_write;
        e.mis    = is_mem && ((off % nb) != 0);
        e.access = is_mem && !e.mis;
        e.addr   = a - 32'(off);
        e.be     = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
        if (e.access && !c.mem_write) begin
            v = word >> (8 * off);
            if (nb < 4) begin
                mask = (32'd1 << (8 * nb)) - 32'd1;
                v    = v & mask;
                if (c.mem_size < 3'd4 && v[8*nb-1]) v = v | ~mask;
            end
            e.load_data = v;
        end
        if (!e.access) e.lat = 32'd1;
        else if (c.mem_write) e.lat = 32'(2 + gd);
        else e.lat = 32'(3 + gd + rdly);
        return e;
    endfunction

    // Presents one bundle, plays the memory side with the given delays and
    // returns what was observed. Stray rvalids are thrown in during REQ.
    task automatic drive_op(input control_type c, input logic [31:0] a, input logic [31:0] sd,
                            input int gd, input int rdly, input logic [31:0] word,
                            output int lat, output int stall_cnt, output bit saw_req,
                            output bit unstable, output bit timed_out,
                            output logic [31:0] q_addr, output logic [3:0] q_be,
                            output logic [31:0] q_wdata, output logic q_we);
        int gcnt;
        int rcnt;
        int guard;
        lat = 0; stall_cnt = 0; saw_req = 0; unstable = 0; timed_out = 0;
        q_addr = '0; q_be = '0; q_wdata = '0; q_we = 1'b0;
        gcnt = 0; rcnt = 0; guard = 0;
        while (stall && guard < 10) begin
            step();
            guard++;
        end
        in_valid = 1'b1; control_in = c; alu_data = a; memory_data = sd;
        step();
        in_valid = 1'b0;
        control_in = 11'($urandom); alu_data = $urandom; memory_data = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (stall) stall_cnt++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (mem_req) begin
                if (!saw_req) begin
                    q_addr = mem_addr; q_be = mem_be; q_wdata = mem_wdata; q_we = mem_we;
                    saw_req = 1;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !==
                             {q_addr, q_be, q_wdata, q_we}) begin
                    unstable = 1;
                end
                mem_gnt    = (gcnt == gd);
                mem_rvalid = 1'($urandom);
                gcnt++;
            end else if (stall) begin
                mem_rvalid = (rcnt == rdly);
                if (mem_rvalid) mem_rdata = word;
                rcnt++;
            end
            step();
            lat++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        if (!out_valid) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        if ({stall, out_valid, mem_req, mem_we, misaligned} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {stall, out_valid, mem_req, mem_we, misaligned});
        end
        checks++;
        if ({mem_addr, mem_be, mem_wdata} !== 68'd0) begin
            errors++;
            $display("FAIL reset_bus got %h/%h/%h want 0", mem_addr, mem_be, mem_wdata);
        end
        checks++;
        if ({load_data, alu_data_out} !== 64'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0", load_data, alu_data_out);
        end
        checks++;
        if (control_out !== control_type'('0)) begin
            errors++;
            $display("FAIL reset_ctrl got %h want 0", control_out);
        end
    endtask

    task automatic test_alu();
        control_type c;
        int lat, sc; bit sr, un, to;
        logic [31:0] qa, qw; logic [3:0] qb; logic qe;
        c = mk_ctrl(1'b0, 1'b0, F3_BYTE, 5'd7);
        drive_op(c, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 32'd0, lat, sc, sr, un, to, qa, qb, qw, qe);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL alu_latency got %0d want 1", lat); end
        checks++;
        if (alu_data_out !== 32'h1234_5678) begin
            errors++; $display("FAIL alu_data_out got %h want 12345678", alu_data_out);
        end
        checks++;
        if (control_out !== c) begin
            errors++; $display("FAIL alu_ctrl got %h want %h", control_out, c);
        end
        checks++;
        if ({sr, sc != 0, stall, misaligned, load_data} !== 36'd0) begin
            errors++;
            $display("FAIL alu_no_access got req=%0b stalls=%0d mis=%0b ld=%h want none",
                     sr, sc, misaligned, load_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || alu_data_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu_pulse_hold got v=%0b d=%h want 0/12345678", out_valid, alu_data_out);
        end
    endtask

    task automatic test_sb();
        control_type c;
        int lat, sc; bit sr, un, to;
        logic [31:0] qa, qw; logic [3:0] qb; logic qe;
        c = mk_ctrl(1'b0, 1'b1, F3_BYTE, 5'd0);
        drive_op(c, 32'h0000_0103, 32'h0000_00AB, 0, 0, 32'd0, lat, sc, sr, un, to, qa, qb, qw, qe);
        checks++;
        if ({sr, qe, qa, qb, qw} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB}) begin
            errors++;
            $display("FAIL sb_bus got req=%0b we=%0b a=%h be=%b wd=%h want 1 1 100 1000 abababab",
                     sr, qe, qa, qb, qw);
        end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL sb_latency got %0d want 2", lat); end
        checks++;
        if ({load_data, alu_data_out} !== {32'd0, 32'h103}) begin
            errors++;
            $display("FAIL sb_out got ld=%h alu=%h want 0/103", load_data, alu_data_out);
        end
    endtask

    task automatic test_lh();
        control_type c;
        int lat, sc; bit sr, un, to;
        logic [31:0] qa, qw; logic [3:0] qb; logic qe;
        logic [31:0] want;
        for (int u = 0; u < 2; u++) begin
            c    = mk_ctrl(1'b1, 1'b0, (u == 0) ? F3_HALF : F3_HALF_U, 5'd3);
            want = (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001;
            drive_op(c, 32'h0000_0102, 32'd0, 2, 0, 32'h8001_0000, lat, sc, sr, un, to,
                     qa, qb, qw, qe);
            checks++;
            if (load_data !== want) begin
                errors++; $display("FAIL lh_data[%0d] got %h want %h", u, load_data, want);
            end
            checks++;
            if (sc !== 4 || lat !== 5) begin
                errors++;
                $display("FAIL lh_timing[%0d] got stall=%0d lat=%0d want 4/5", u, sc, lat);
            end
            checks++;
            if ({qe, qa, qb, un} !== {1'b0, 32'h100, 4'b1100, 1'b0}) begin
                errors++;
                $display("FAIL lh_bus[%0d] got we=%0b a=%h be=%b unstable=%0b want 0 100 1100 0",
                         u, qe, qa, qb, un);
            end
        end
    endtask

    task automatic test_misaligned();
        control_type c;
        int lat, sc; bit sr, un, to;
        logic [31:0] qa, qw; logic [3:0] qb; logic qe;
        c = mk_ctrl(1'b1, 1'b0, F3_WORD, 5'd5);
        drive_op(c, 32'h0000_0006, 32'd0, 0, 0, 32'hFFFF_FFFF, lat, sc, sr, un, to,
                 qa, qb, qw, qe);
        checks++;
        if ({misaligned, sr, load_data} !== {1'b1, 1'b0, 32'd0} || lat !== 1) begin
            errors++;
            $display("FAIL lw_misaligned got mis=%0b req=%0b ld=%h lat=%0d want 1 0 0 1",
                     misaligned, sr, load_data, lat);
        end
    endtask

    task automatic test_back_to_back();
        control_type ops[3];
        logic [31:0] addrs[3];
        control_type c;
        exp_t e;
        int lat, sc, gd, rd; bit sr, un, to;
        logic [31:0] qa, qw, sd, word; logic [3:0] qb; logic qe;
        ops[0] = mk_ctrl(1'b1, 1'b0, F3_BYTE, 5'd11);
        ops[1] = mk_ctrl(1'b0, 1'b0, F3_WORD, 5'd12);
        ops[2] = mk_ctrl(1'b0, 1'b1, F3_WORD, 5'd13);
        addrs[0] = $urandom;
        addrs[1] = $urandom;
        addrs[2] = $urandom & 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            c = ops[i]; sd = $urandom; word = $urandom;
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            e = model_op(c, addrs[i], sd, word, gd, rd);
            drive_op(c, addrs[i], sd, gd, rd, word, lat, sc, sr, un, to, qa, qb, qw, qe);
            checks++;
            if (to || lat !== int'(e.lat) || un) begin
                errors++;
                $display("FAIL b2b_timing[%0d] got lat=%0d to=%0b unstable=%0b want lat=%0d",
                         i, lat, to, un, e.lat);
            end
            checks++;
            if ({control_out, alu_data_out, load_data, misaligned} !==
                {c, addrs[i], e.load_data, e.mis}) begin
                errors++;
                $display("FAIL b2b_out[%0d] got c=%h a=%h ld=%h mis=%0b want %h %h %h %0b", i,
                         control_out, alu_data_out, load_data, misaligned,
                         c, addrs[i], e.load_data, e.mis);
            end
            checks++;
            if (sr !== e.access || (e.access && {qa, qb, qw, qe} !==
                {e.addr, e.be, e.wdata, c.mem_write})) begin
                errors++;
                $display("FAIL b2b_bus[%0d] got req=%0b a=%h be=%b wd=%h we=%0b want %0b %h %b %h",
                         i, sr, qa, qb, qw, qe, e.access, e.addr, e.be, e.wdata);
            end
        end
    endtask

    task automatic test_random();
        control_type c;
        exp_t e;
        int lat, sc, gd, rd, kind; bit sr, un, to;
        logic [31:0] qa, qw, sd, word, a; logic [3:0] qb; logic qe;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            c    = mk_ctrl(kind == 1, kind == 2, 3'($urandom), 5'($urandom));
            a    = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            sd   = $urandom; word = $urandom;
            gd   = $urandom_range(0, 3); rd = $urandom_range(0, 3);
            e    = model_op(c, a, sd, word, gd, rd);
            drive_op(c, a, sd, gd, rd, word, lat, sc, sr, un, to, qa, qb, qw, qe);
            checks++;
            if (to || lat !== int'(e.lat) || un || sc !== int'(e.lat) - 1) begin
                errors++;
                $display("FAIL rand_timing[%0d] got lat=%0d stall=%0d to=%0b un=%0b want lat=%0d",
                         i, lat, sc, to, un, e.lat);
            end
            checks++;
            if ({control_out, alu_data_out, load_data, misaligned} !==
                {c, a, e.load_data, e.mis}) begin
                errors++;
                $display("FAIL rand_out[%0d] got c=%h a=%h ld=%h mis=%0b want %h %h %h %0b", i,
                         control_out, alu_data_out, load_data, misaligned,
                         c, a, e.load_data, e.mis);
            end
            checks++;
            if (sr !== e.access || (e.access && {qa, qb, qw, qe} !==
                {e.addr, e.be, e.wdata, c.mem_write})) begin
                errors++;
                $display("FAIL rand_bus[%0d] got req=%0b a=%h be=%b wd=%h we=%0b want %0b %h %b %h",
                         i, sr, qa, qb, qw, qe, e.access, e.addr, e.be, e.wdata);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        control_type c;
        bit seen;
        c = mk_ctrl(1'b1, 1'b0, F3_WORD, 5'd9);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        // Reset while requesting: mem_req must drop without a clock edge.
        in_valid = 1'b1; control_in = c; alu_data = 32'h40;
        step();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre got %0b want 1", mem_req); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL rst_async got req=%0b stall=%0b want 0 0", mem_req, stall);
        end
        step();
        reset = 1'b0;
        step();
        // Reset while waiting for the response, then a late rvalid.
        in_valid = 1'b1; control_in = c; alu_data = 32'h80;
        step();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++;
        if ({stall, mem_req} !== 2'b10) begin
            errors++; $display("FAIL rst_in_resp got stall=%0b req=%0b want 1 0", stall, mem_req);
        end
        #2 reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        seen = 0;
        repeat (3) begin
            step();
            if (out_valid) seen = 1;
        end
        mem_rvalid = 1'b0;
        checks++;
        if (seen) begin errors++; $display("FAIL rst_stray_rvalid got out_valid=1 want 0"); end
        checks++;
        if ({stall, out_valid, mem_req, mem_we, misaligned, mem_addr, mem_be, mem_wdata,
             load_data, alu_data_out, control_out} !== '0) begin
            errors++;
            $display("FAIL rst_outputs got st=%0b req=%0b a=%h be=%b ld=%h alu=%h c=%h want 0",
                     stall, mem_req, mem_addr, mem_be, load_data, alu_data_out, control_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_sb();
        test_lh();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
